// File: rtl/bp_pkg.sv
// ==== bp_pkg : shared types for the branch predictor ====
// Rev 1.0 - counter-state encodings and the tracking-slot layout
`default_nettype none

package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Slot index field is sized for the widest possible PC-derived index
  localparam int BP_IDX_MAX_W = 30;

  typedef logic [1:0] bp_state_t;

  typedef struct packed {
    logic                    valid;
    logic                    pred;
    logic [BP_IDX_MAX_W-1:0] idx;
  } bp_slot_t;

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_counter2.sv
// ==== sat_counter2 : 2-bit saturating counter next-state ====
// Rev 1.0 - increments on taken, decrements on not-taken, clamps at ST/SNT
`default_nettype none

module sat_counter2
  import bp_pkg::*;
(
  input  bp_state_t state_i,
  input  logic      taken_i,
  output bp_state_t next_o
);

  always_comb begin
    next_o = state_i;
    if (taken_i) begin
      if (state_i != ST) next_o = state_i + 2'd1;
    end else begin
      if (state_i != SNT) next_o = state_i - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ==== branch_predictor : 2-bit BHT predictor with IF->ID->EXE tracking ====
// Rev 1.0 - optional BP_PERF_EN adds branch_count / mispredict_count outputs
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int        BHT_ENTRIES = 64,
  parameter int        IDX_W       = $clog2(BHT_ENTRIES),
  parameter bp_state_t INIT_STATE  = WNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_PC,
  input  logic        IF_is_branch,
  input  logic        stall,
  input  logic        flush,
  input  logic        EXE_resolve,
  input  logic        EXE_taken,
  output logic        prediction,
  output logic        misprediction
`ifdef BP_PERF_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
`endif
);

  bp_state_t        bht_q [BHT_ENTRIES];
  bp_slot_t         if_q, id_q, exe_q;
  bp_slot_t         if_d, id_d, exe_d;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] exe_idx;
  bp_state_t        exe_cnt_next;
  logic             train;
  logic             kill;
  logic             unused_bits;

  assign if_idx        = IF_PC[IDX_W+1:2];
  assign exe_idx       = exe_q.idx[IDX_W-1:0];
  assign prediction    = bht_q[if_idx][1];
  assign train         = exe_q.valid & EXE_resolve & ~stall;
  assign misprediction = train & (EXE_taken != exe_q.pred);
  assign kill          = misprediction | flush;
  assign unused_bits   = ^{IF_PC[1:0], IF_PC[31:IDX_W+2], exe_q.idx};

  sat_counter2 u_sat (
    .state_i (bht_q[exe_idx]),
    .taken_i (EXE_taken),
    .next_o  (exe_cnt_next)
  );

  // A flush under stall still kills the younger slots; EXE only moves when not stalled
  always_comb begin
    if_d  = if_q;
    id_d  = id_q;
    exe_d = exe_q;
    if (!stall) begin
      exe_d = id_q;
      id_d  = if_q;
      if_d  = '{valid: IF_is_branch, pred: prediction, idx: BP_IDX_MAX_W'(if_idx)};
    end
    if (kill) begin
      if_d.valid = 1'b0;
      id_d.valid = 1'b0;
      if (!stall) exe_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_q  <= '0;
      id_q  <= '0;
      exe_q <= '0;
    end else begin
      if_q  <= if_d;
      id_q  <= id_d;
      exe_q <= exe_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= INIT_STATE;
    end else if (train) begin
      bht_q[exe_idx] <= exe_cnt_next;
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (train)         branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (misprediction) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispredict_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ==== tb_branch_predictor : self-checking bench for branch_predictor ====
// Rev 1.0 - directed scenarios plus randomized traffic against a reference model
`default_nettype none

module tb_branch_predictor;

  localparam int BHT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IF_PC = 32'd0;
  logic        IF_is_branch = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        EXE_resolve = 1'b0;
  logic        EXE_taken = 1'b0;
  logic        prediction;
  logic        misprediction;
`ifdef BP_PERF_EN
  logic [31:0] branch_count, mispredict_count;
`endif

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IF_PC         (IF_PC),
    .IF_is_branch  (IF_is_branch),
    .stall         (stall),
    .flush         (flush),
    .EXE_resolve   (EXE_resolve),
    .EXE_taken     (EXE_taken),
    .prediction    (prediction),
    .misprediction (misprediction)
`ifdef BP_PERF_EN
    ,
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: counter values as plain integers 0..3, in-flight branches as a 3-deep pipe
  typedef struct {
    bit v;
    bit p;
    int idx;
  } ent_t;

  int   cnt [BHT];
  ent_t pipe [3];
  int   bc, mc;
  logic obs_pred, obs_mis;
  logic [31:0] obs_bc, obs_mc;

  function automatic void model_reset();
    for (int i = 0; i < BHT; i++) cnt[i] = 1;
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, p: 1'b0, idx: 0};
    bc = 0;
    mc = 0;
  endfunction

  task automatic cyc(input logic [31:0] pc, input logic br, input logic st, input logic fl,
                     input logic rs, input logic tk);
    int  i;
    bit  ep, em, tr;
    @(negedge clk);
    IF_PC = pc; IF_is_branch = br; stall = st; flush = fl; EXE_resolve = rs; EXE_taken = tk;
    #1;
    i  = int'(pc >> 2) % BHT;
    ep = (cnt[i] >= 2);
    tr = pipe[2].v && rs && !st;
    em = tr && (tk != pipe[2].p);
    obs_pred = prediction;
    obs_mis  = misprediction;
    nchk++;
    if (prediction !== ep) begin
      nerr++;
      $display("FAIL prediction pc=%h t=%0t: got %b expected %b", pc, $time, prediction, ep);
    end
    nchk++;
    if (misprediction !== em) begin
      nerr++;
      $display("FAIL misprediction pc=%h t=%0t: got %b expected %b", pc, $time, misprediction, em);
    end
`ifdef BP_PERF_EN
    obs_bc = branch_count;
    obs_mc = mispredict_count;
    nchk++;
    if (branch_count !== 32'(bc) || mispredict_count !== 32'(mc)) begin
      nerr++;
      $display("FAIL perf counters t=%0t: got %0d/%0d expected %0d/%0d",
               $time, branch_count, mispredict_count, bc, mc);
    end
`endif
    @(posedge clk);
    if (tr) begin
      if (tk) begin
        if (cnt[pipe[2].idx] < 3) cnt[pipe[2].idx]++;
      end else if (cnt[pipe[2].idx] > 0) begin
        cnt[pipe[2].idx]--;
      end
      bc++;
    end
    if (em) mc++;
    if (!st) begin
      if (em || fl) begin
        pipe[2].v = 1'b0;
        pipe[1].v = 1'b0;
        pipe[0].v = 1'b0;
      end else begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{v: br, p: ep, idx: i};
      end
    end else if (fl) begin
      pipe[1].v = 1'b0;
      pipe[0].v = 1'b0;
    end
  endtask

  // Branch enters IF, travels two idle cycles, resolves in EXE on the fourth cycle
  task automatic issue(input logic [31:0] pc, input logic tk);
    cyc(pc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(pc, 1'b0, 1'b0, 1'b0, 1'b1, tk);
  endtask

  task automatic probe(input logic [31:0] pc);
    cyc(pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_bit(input string name, input logic got, input logic exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    IF_PC = 32'h100; IF_is_branch = 1'b0; stall = 1'b0; flush = 1'b0;
    EXE_resolve = 1'b0; EXE_taken = 1'b0;
    rst_n = 1'b0;
    #1;
    nchk++;
    if (prediction !== 1'b0 || misprediction !== 1'b0) begin
      nerr++;
      $display("FAIL reset outputs: got pred=%b mis=%b expected 0/0", prediction, misprediction);
    end
`ifdef BP_PERF_EN
    nchk++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      nerr++;
      $display("FAIL reset perf: got %0d/%0d expected 0/0", branch_count, mispredict_count);
    end
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    probe(32'h100);
    expect_bit("reset pred 0x100", obs_pred, 1'b0);
    expect_bit("reset mis", obs_mis, 1'b0);
  endtask

  task automatic test_train_saturate();
    do_reset();
    issue(32'h100, 1'b1);
    expect_bit("first taken mispredicts", obs_mis, 1'b1);
    probe(32'h100);
    expect_bit("pred after 1 taken", obs_pred, 1'b1);
    issue(32'h100, 1'b1);
    expect_bit("second taken correct", obs_mis, 1'b0);
    issue(32'h100, 1'b1);
    probe(32'h100);
    expect_bit("pred after 3 taken", obs_pred, 1'b1);
    issue(32'h100, 1'b0);
    probe(32'h100);
    expect_bit("saturated then one NT", obs_pred, 1'b1);
  endtask

  task automatic test_mispredict();
    do_reset();
    cyc(32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h204, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h208, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h20C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_bit("mispredict raised", obs_mis, 1'b1);
    cyc(32'h210, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_bit("EXE invalid after mispredict", obs_mis, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_bit("old ID slot cleared", obs_mis, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_bit("old IF slot cleared", obs_mis, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_bit("correct-path branch resolves", obs_mis, 1'b1);
  endtask

  task automatic test_correct_predict();
    do_reset();
    issue(32'h200, 1'b1);
    issue(32'h200, 1'b1);
    issue(32'h200, 1'b1);
    expect_bit("predicted T resolved T", obs_mis, 1'b0);
    probe(32'h200);
    expect_bit("stays taken", obs_pred, 1'b1);
  endtask

  task automatic test_stall();
    do_reset();
    cyc(32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_bit("stalled resolve no mis", obs_mis, 1'b0);
    cyc(32'h300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_bit("stalled resolve no mis 2", obs_mis, 1'b0);
    cyc(32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_bit("released resolve mis", obs_mis, 1'b1);
    expect_bit("released pred old", obs_pred, 1'b0);
    cyc(32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_bit("single mis after release", obs_mis, 1'b0);
    expect_bit("single update pred", obs_pred, 1'b1);
    issue(32'h300, 1'b0);
    probe(32'h300);
    expect_bit("exactly one update", obs_pred, 1'b0);
  endtask

  task automatic test_same_idx();
    do_reset();
    issue(32'h14, 1'b1);
    expect_bit("same-idx read old", obs_pred, 1'b0);
    probe(32'h14);
    expect_bit("same-idx read new", obs_pred, 1'b1);
  endtask

  task automatic test_flush();
    do_reset();
    cyc(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h48, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_bit("flushed slot ignored", obs_mis, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    IF_PC = 32'hC; EXE_resolve = 1'b1; EXE_taken = 1'b1;
    #1;
    expect_bit("mis before async reset", misprediction, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    expect_bit("mis during async reset", misprediction, 1'b0);
    expect_bit("pred during async reset", prediction, 1'b0);
    @(negedge clk);
    EXE_resolve = 1'b0; EXE_taken = 1'b0;
    model_reset();
    rst_n = 1'b1;
    probe(32'hC);
    expect_bit("in-flight update discarded", obs_pred, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
      cyc(pc, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef BP_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int k = 0; k < 10; k++) issue(32'(k * 4), (k < 3));
    probe(32'h0);
    nchk++;
    if (obs_bc !== 32'd10 || obs_mc !== 32'd3) begin
      nerr++;
      $display("FAIL perf totals: got %0d/%0d expected 10/3", obs_bc, obs_mc);
    end
    cyc(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_train_saturate();
    test_mispredict();
    test_correct_predict();
    test_stall();
    test_same_idx();
    test_flush();
    test_async_reset();
`ifdef BP_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
